dma_irq_vector_scheduler: RTL
=============================

// Module: dma_irq_vector_scheduler
// PURPOSE
//  Collects frame/DMA completion events from NUM_SRC sources and round-robin arbitrates them.
//  Queues granted source IDs into a vector FIFO. The processor reads one vector at a time and
//  acknowledges it (pop). Sits between the DMA channels and the processor interrupt line.
// PARAMETERS
//  NUM_SRC     4  number of event sources; must satisfy NUM_SRC <= 2**VEC_WIDTH
//  VEC_WIDTH   2  width of a vector ID
//  FIFO_DEPTH  8  vector FIFO entries; power of two
//  ADDR_WIDTH  3  log2(FIFO_DEPTH)
// PORTS
//  sys_clk_i      in   1            system clock; all logic on rising edge
//  rst_i          in   1            synchronous reset, active high
//  src_event_i    in   NUM_SRC      per-source event level; rising edge = one event (sys_clk_i domain)
//  src_en_i       in   NUM_SRC      per-source enable
//  global_en_i    in   1            global event enable
//  vec_ack_i      in   1            processor pop of head vector
//  overflow_clr_i in   NUM_SRC      clears matching overflow_o bits
//  vec_valid_o    out  1            FIFO non-empty; vec_id_o valid
//  vec_id_o       out  VEC_WIDTH    head-of-FIFO source ID (show-ahead)
//  pending_o      out  NUM_SRC      per-source pending (captured, not yet queued)
//  fifo_level_o   out  ADDR_WIDTH+1 entries in FIFO, 0..FIFO_DEPTH
//  irq_o          out  1            interrupt to processor; equals vec_valid_o
//  overflow_o     out  NUM_SRC      sticky: event lost because the source was already pending
// BEHAVIOUR
//  Reset (rst_i high at a clock edge): all outputs 0, FIFO empty, edge regs 0.
//   RR pointer last_grant = NUM_SRC-1, so source 0 has top priority first.
//   Reset mid-operation discards all pending and queued vectors.
//  Edge detect:
//   src_dly <= src_event_i each cycle.
//   rise[i] = src_event_i[i] & ~src_dly[i] & src_en_i[i] & global_en_i.
//  Pending:
//   rise[i] sets pending[i] at the same edge.
//   A grant to i clears pending[i], unless rise[i] occurs in that same cycle; then pending stays 1.
//   rise[i] while pending[i]=1 and no grant to i: the event is merged and overflow_o[i] <= 1.
//   overflow_o[i] is held until overflow_clr_i[i]. If clear and a new overflow coincide, the bit stays set.
//   src_en_i[i] low clears pending[i] next edge. Entries already queued are kept.
//  Arbiter:
//   Each cycle, if |pending and fifo_level_o < FIFO_DEPTH, grant exactly one source.
//   The granted source is the first pending index after last_grant, searching upward with wrap at NUM_SRC-1 -> 0.
//   On grant: push ID into FIFO; update last_grant.
//   Full FIFO: no grant, and pending bits are held. A pop in the same cycle does not enable a push.
//   A push occurs the cycle after level drops.
//  FIFO:
//   Pop when vec_valid_o & vec_ack_i. vec_ack_i while empty is ignored.
//   Simultaneous push and pop: level unchanged, ordering preserved.
//   Read/write pointers are ADDR_WIDTH wide and wrap naturally. Level is tracked separately (ADDR_WIDTH+1 bits).
//   vec_id_o is the registered head; it updates the edge after a pop or after the first push into an empty FIFO.
//  Latency:
//   src_event_i rises before edge n -> pending_o=1 after edge n.
//   -> push at edge n+1 -> vec_valid_o/irq_o=1 after edge n+1 (2 cycles), if uncontested and FIFO not full.
//   After an ack at edge m, vec_valid_o drops after edge m when the FIFO becomes empty.
// TESTING
//  1 src_event_i=4'b0100 at cycle 0 -> pending_o[2]=1 at cycle 1; vec_valid_o=1, vec_id_o=2, level=1 at cycle 2;
//    ack at cycle 3 -> valid=0, level=0 at cycle 4.
//  2 Rising edges on sources 0, 1, 3 in the same cycle, no ack -> IDs 0, 1, 3 pushed on consecutive cycles;
//    level=3; acks return 0, 1, 3 in order.
//  3 last_grant=0, sources 0 and 1 both pending -> source 1 granted first, then 0.
//    Repeated retriggers alternate 0/1; no starvation.
//  4 Nine events with no ack -> level saturates at 8, ninth stays in pending_o.
//    One ack -> level 7, then push -> level 8 again. overflow_o stays 0.
//  5 Source 1 edge, drop, edge again while FIFO full -> overflow_o[1]=1 and stays set;
//    overflow_clr_i[1] pulse -> 0 next cycle.
//  6 rst_i for 1 cycle with level=5 and pending=4'b1010 -> all outputs 0 next cycle;
//    the next event on source 0 is serviced first.

Source files
------------

// File: rtl/dma_irq_vector_scheduler_if.sv
// rtl/dma_irq_vector_scheduler_if.sv - vector pop handshake between scheduler and processor
interface dma_irq_vector_scheduler_if #(
    parameter int VEC_WIDTH = 2
);
    logic                 vec_valid_o;
    logic [VEC_WIDTH-1:0] vec_id_o;
    logic                 irq_o;
    logic                 vec_ack_i;

    modport master (
        input  vec_valid_o,
        input  vec_id_o,
        input  irq_o,
        output vec_ack_i
    );

    modport slave (
        output vec_valid_o,
        output vec_id_o,
        output irq_o,
        input  vec_ack_i
    );
endinterface

// File: rtl/dma_irq_vector_scheduler.sv
// rtl/dma_irq_vector_scheduler.sv - edge-captured event sources, round-robin arbiter, vector FIFO
module dma_irq_vector_scheduler #(
    parameter int NUM_SRC    = 4,
    parameter int VEC_WIDTH  = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  sys_clk_i,
    input  logic                  rst_i,
    input  logic [NUM_SRC-1:0]    src_event_i,
    input  logic [NUM_SRC-1:0]    src_en_i,
    input  logic                  global_en_i,
    input  logic [NUM_SRC-1:0]    overflow_clr_i,
    output logic [NUM_SRC-1:0]    pending_o,
    output logic [ADDR_WIDTH:0]   fifo_level_o,
    output logic [NUM_SRC-1:0]    overflow_o,
    dma_irq_vector_scheduler_if.slave vec_if
);

    localparam logic [ADDR_WIDTH:0]   FULL_LEVEL = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0]   LEVEL_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);
    localparam logic [VEC_WIDTH-1:0]  LAST_INIT  = VEC_WIDTH'(NUM_SRC - 1);

    logic [NUM_SRC-1:0]    src_dly;
    logic [NUM_SRC-1:0]    pending;
    logic [NUM_SRC-1:0]    overflow;
    logic [NUM_SRC-1:0]    rise;
    logic [NUM_SRC-1:0]    grant;
    logic [VEC_WIDTH-1:0]  grant_id;
    logic [VEC_WIDTH-1:0]  last_grant;
    logic                  can_push;
    logic                  push;
    logic                  pop;
    logic                  found;
    int                    idx;

    logic [VEC_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   level;
    logic [VEC_WIDTH-1:0]  head_q;

    assign rise     = src_event_i & ~src_dly & src_en_i & {NUM_SRC{global_en_i}};
    // Full-check uses the registered level, so a same-cycle pop never frees a slot for a push.
    assign can_push = (|pending) && (level != FULL_LEVEL);
    assign push     = |grant;
    assign pop      = (level != '0) && vec_if.vec_ack_i;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = (int'(last_grant) + k) % NUM_SRC;
            if (can_push && !found && pending[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = VEC_WIDTH'(idx);
            end
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            src_dly    <= '0;
            pending    <= '0;
            overflow   <= '0;
            last_grant <= LAST_INIT;
        end else begin
            src_dly <= src_event_i;
            if (push) begin
                last_grant <= grant_id;
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!src_en_i[i]) begin
                    pending[i] <= 1'b0;
                end else if (rise[i]) begin
                    pending[i] <= 1'b1;
                end else if (grant[i]) begin
                    pending[i] <= 1'b0;
                end
                // A new lost event wins over a coincident clear.
                if (rise[i] && pending[i] && !grant[i]) begin
                    overflow[i] <= 1'b1;
                end else if (overflow_clr_i[i]) begin
                    overflow[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (push) begin
            mem[wr_ptr] <= grant_id;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            head_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                level <= level + LEVEL_ONE;
            end else if (pop && !push) begin
                level <= level - LEVEL_ONE;
            end
            // With one entry left the next head is the word being pushed this cycle, not yet in mem.
            if (pop) begin
                if (level == LEVEL_ONE) begin
                    if (push) begin
                        head_q <= grant_id;
                    end
                end else begin
                    head_q <= mem[rd_ptr + PTR_ONE];
                end
            end else if (push && (level == '0)) begin
                head_q <= grant_id;
            end
        end
    end

    assign pending_o          = pending;
    assign overflow_o         = overflow;
    assign fifo_level_o       = level;
    assign vec_if.vec_valid_o = (level != '0);
    assign vec_if.irq_o       = (level != '0);
    assign vec_if.vec_id_o    = head_q;

endmodule
